// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel edge-magnitude writer.
package sobel_pkg;

    // Struct fields are sized for the largest supported configuration.
    // The top module narrows them to the actual output widths.
    localparam int PIX_MAX_W   = 16;
    localparam int COORD_MAX_W = 16;

    typedef struct packed {
        logic [PIX_MAX_W-1:0]   pix;
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } edge_pix_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        ACTIVE = 2'd2,
        FLUSH  = 2'd3
    } wr_state_e;

    // Shift the magnitude right, then clamp it to the largest out_w-bit value.
    function automatic logic [PIX_MAX_W-1:0] sat_shift(input logic [31:0] mag,
                                                       input int          shift,
                                                       input int          out_w);
        logic [31:0] val;
        logic [31:0] max_val;
        val     = mag >> shift;
        max_val = (32'd1 << out_w) - 32'd1;
        if (val > max_val) begin
            val = max_val;
        end
        return val[PIX_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_edge_writer_fifo.sv
// First-word-fall-through FIFO.
// The head entry is read combinationally from the storage array, so a word
// that is pushed into an empty FIFO becomes visible on the next cycle.
module sync_fifo_fwft #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_valid,
    output logic o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           full;
    logic           push_ok;
    logic           pop_ok;

    assign o_valid = (count_reg != '0);
    assign full    = (count_reg == FULL_CNT);
    assign pop_ok  = i_pop && o_valid;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push_ok = i_push && (!full || pop_ok);
    assign o_drop  = i_push && !push_ok;
    assign o_data  = mem[rd_ptr_reg];

    // Storage write; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sobel_edge_writer.sv
// Consumer end of the Sobel magnitude stream.
// Re-aligns each sample to its window centre, blanks border pixels, scales the
// magnitude to display width and queues the tagged pixels for a ready/valid sink.
module sobel_edge_writer
    import sobel_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int MAG_W       = 18,
    parameter int OUT_W       = 12,
    parameter int SHIFT       = 6,
    parameter int FIFO_DEPTH  = 16,
    parameter int ZERO_BORDER = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_frame_start,
    input  logic                     i_mag_valid,
    input  logic [MAG_W-1:0]         i_mag,
    output logic                     o_flush_req,
    output logic                     o_pix_valid,
    input  logic                     i_pix_ready,
    output logic [OUT_W-1:0]         o_pix,
    output logic [$clog2(IMG_W)-1:0] o_x,
    output logic [$clog2(IMG_H)-1:0] o_y,
    output logic                     o_sof,
    output logic                     o_eol,
    output logic                     o_eof,
    output logic                     o_overflow,
    output logic                     o_frame_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    // The sample counter runs from the frame start to the last flush sample.
    localparam int NW = $clog2(IMG_W * IMG_H + IMG_W + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WARMUP = WARMUP;
    localparam logic [1:0] S_ACTIVE = ACTIVE;
    localparam logic [1:0] S_FLUSH  = FLUSH;

    localparam logic [NW-1:0] N_WARM_LAST  = NW'(IMG_W);
    localparam logic [NW-1:0] N_ACT_LAST   = NW'(IMG_W * IMG_H - 1);
    localparam logic [NW-1:0] N_FLUSH_LAST = NW'(IMG_W * IMG_H + IMG_W);
    localparam logic [XW-1:0] X_LAST       = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(IMG_H - 1);

    logic [1:0]    state_reg, state_next;
    logic [NW-1:0] n_reg, n_next;
    logic [XW-1:0] cx_reg, cx_next;
    logic [YW-1:0] cy_reg, cy_next;
    logic          emit;
    logic          border;
    edge_pix_t     emit_data;
    logic          push_valid_reg;
    edge_pix_t     push_data_reg;
    logic          overflow_reg;
    logic          frame_done_reg;
    edge_pix_t     head;
    logic          fifo_valid;
    logic          fifo_drop;
    logic          pop;
    logic          unused_head;

    // Sequencing: sample counting, state transitions and centre coordinates.
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        cx_next    = cx_reg;
        cy_next    = cy_reg;
        emit       = 1'b0;
        if (i_frame_start) begin
            // A coincident sample is the first sample of the new frame.
            state_next = S_WARMUP;
            n_next     = i_mag_valid ? NW'(1) : '0;
            cx_next    = '0;
            cy_next    = '0;
        end else if (i_mag_valid && (state_reg != S_IDLE)) begin
            n_next = n_reg + 1'b1;
            case (state_reg)
                S_WARMUP: begin
                    if (n_reg == N_WARM_LAST) state_next = S_ACTIVE;
                end
                S_ACTIVE: begin
                    emit = 1'b1;
                    if (n_reg == N_ACT_LAST) state_next = S_FLUSH;
                end
                S_FLUSH: begin
                    emit = 1'b1;
                    if (n_reg == N_FLUSH_LAST) state_next = S_IDLE;
                end
                default: ;
            endcase
            if (emit) begin
                if (cx_reg == X_LAST) begin
                    cx_next = '0;
                    cy_next = (cy_reg == Y_LAST) ? '0 : cy_reg + 1'b1;
                end else begin
                    cx_next = cx_reg + 1'b1;
                end
            end
        end
    end

    // Result for the current centre: scaled pixel plus position tags.
    always_comb begin
        border        = (cx_reg == '0) || (cx_reg == X_LAST) ||
                        (cy_reg == '0) || (cy_reg == Y_LAST);
        emit_data     = '0;
        emit_data.pix = (border && (ZERO_BORDER != 0)) ? '0 :
                        sat_shift(32'(i_mag), SHIFT, OUT_W);
        emit_data.x   = COORD_MAX_W'(cx_reg);
        emit_data.y   = COORD_MAX_W'(cy_reg);
        emit_data.sof = (cx_reg == '0) && (cy_reg == '0);
        emit_data.eol = (cx_reg == X_LAST);
        emit_data.eof = (cx_reg == X_LAST) && (cy_reg == Y_LAST);
    end

    // State, counters, the registered FIFO push and the status flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= S_IDLE;
            n_reg          <= '0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            push_valid_reg <= 1'b0;
            push_data_reg  <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            n_reg          <= n_next;
            cx_reg         <= cx_next;
            cy_reg         <= cy_next;
            push_valid_reg <= emit;
            push_data_reg  <= emit_data;
            if (i_frame_start) begin
                overflow_reg <= 1'b0;
            end else if (fifo_drop) begin
                overflow_reg <= 1'b1;
            end
            frame_done_reg <= pop && head.eof;
        end
    end

    assign pop = fifo_valid && i_pix_ready;

    sync_fifo_fwft #(
        .T     (edge_pix_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_valid_reg),
        .i_data  (push_data_reg),
        .i_pop   (pop),
        .o_data  (head),
        .o_valid (fifo_valid),
        .o_drop  (fifo_drop)
    );

    // Head fields are masked while the FIFO is empty so idle outputs read as 0.
    assign o_pix_valid  = fifo_valid;
    assign o_pix        = fifo_valid ? head.pix[OUT_W-1:0] : '0;
    assign o_x          = fifo_valid ? head.x[XW-1:0] : '0;
    assign o_y          = fifo_valid ? head.y[YW-1:0] : '0;
    assign o_sof        = fifo_valid && head.sof;
    assign o_eol        = fifo_valid && head.eol;
    assign o_eof        = fifo_valid && head.eof;
    assign o_flush_req  = (state_reg == S_FLUSH);
    assign o_overflow   = overflow_reg;
    assign o_frame_done = frame_done_reg;
    assign unused_head  = ^head;

endmodule

// File: tb/tb_sobel_edge_writer.sv
// Randomized scoreboard bench for sobel_edge_writer (8x6 image, 8-bit output).
module tb_sobel_edge_writer;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int MAG_W = 18;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;
    localparam int DEPTH = 16;
    localparam int TOTAL = W * H + W + 1;
    localparam int PMAX  = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic             mag_valid = 1'b0;
    logic [MAG_W-1:0] mag = '0;
    logic             pix_ready = 1'b1;
    logic             flush_req, pix_valid, sof, eol, eof, overflow, frame_done;
    logic [OUT_W-1:0] pix;
    logic [2:0]       x, y;

    typedef struct {
        int pix;
        int x;
        int y;
        int tags;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   ref_n = -1;
    int   cap = -1;
    int   pushed = 0;
    int   ready_pct = 100;
    int   flush_cnt = 0;
    int   sof_cnt = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0;
    bit   done_expect = 1'b0;

    sobel_edge_writer #(
        .IMG_W(W), .IMG_H(H), .MAG_W(MAG_W), .OUT_W(OUT_W),
        .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH), .ZERO_BORDER(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
        .i_mag_valid(mag_valid), .i_mag(mag), .o_flush_req(flush_req),
        .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix(pix),
        .o_x(x), .o_y(y), .o_sof(sof), .o_eol(eol), .o_eof(eof),
        .o_overflow(overflow), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Reference: the sample with frame index n centres pixel c = n-(W+1) in raster order.
    function automatic void model_sample(input int m);
        int c, cx, cy, v, tg;
        if (ref_n >= W + 1) begin
            c  = ref_n - (W + 1);
            cx = c % W;
            cy = c / W;
            v  = m >> SHIFT;
            if (v > PMAX) v = PMAX;
            if (cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1) v = 0;
            tg = ((cx == 0 && cy == 0) ? 4 : 0) + ((cx == W - 1) ? 2 : 0) +
                 ((cx == W - 1 && cy == H - 1) ? 1 : 0);
            if (cap < 0 || pushed < cap) exp_q.push_back('{v, cx, cy, tg});
            pushed++;
        end
        ref_n++;
        if (ref_n == TOTAL) ref_n = -1;
    endfunction

    function automatic int mag_for(input int mode, input int s);
        case (mode)
            0:       return 0;
            1:       return s * 16;
            2:       return 'h3FFFF;
            default: return int'($urandom_range(0, (1 << MAG_W) - 1));
        endcase
    endfunction

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cycle(input bit fs, input bit v, input int m);
        if (v && !fs && ref_n >= 0) flush_cnt += int'(flush_req);
        frame_start = fs;
        mag_valid   = v;
        mag         = MAG_W'(m);
        pix_ready   = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (fs) ref_n = 0;
        if (v && ref_n >= 0) model_sample(m);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int mode, input int vpct, input int stop_at, input bit force_v);
        int s;
        s = 0;
        if (force_v || $urandom_range(0, 1) == 1) begin
            cycle(1'b1, 1'b1, mag_for(mode, 0));
            s = 1;
        end else begin
            cycle(1'b1, 1'b0, 0);
        end
        while (s < TOTAL && s != stop_at) begin
            if ($urandom_range(0, 99) < vpct) begin
                cycle(1'b0, 1'b1, mag_for(mode, s));
                s++;
            end else begin
                cycle(1'b0, 1'b0, 0);
            end
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pix_valid) && k < 400) begin
            cycle(1'b0, 1'b0, 0);
            k++;
        end
        repeat (3) cycle(1'b0, 1'b0, 0);
        check(nm, exp_q.size(), 0);
    endtask

    function automatic void clear_counts();
        sof_cnt = 0; eol_cnt = 0; eof_cnt = 0; done_cnt = 0; flush_cnt = 0;
    endfunction

    function automatic int out_word();
        return int'({flush_req, pix_valid, pix, x, y, sof, eol, eof, overflow, frame_done});
    endfunction

    // Monitor: pops the scoreboard on every accepted pixel, checks frame_done timing.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            done_expect = 1'b0;
            continue;
        end
        if (done_expect || frame_done)
            check("frame_done", int'(frame_done), int'(done_expect));
        if (frame_done) done_cnt++;
        done_expect = 1'b0;
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pix", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pix", int'(pix), e.pix);
                check("x", int'(x), e.x);
                check("y", int'(y), e.y);
                check("tags", int'({sof, eol, eof}), e.tags);
                sof_cnt += int'(sof);
                eol_cnt += int'(eol);
                eof_cnt += int'(eof);
                if (e.tags % 2 == 1) done_expect = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_word(), 0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 0);

        // Zero magnitudes, then idle samples that must be ignored.
        clear_counts();
        run_frame(0, 70, -1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 100);
        drain("t1_drain");
        check("t1_sof", sof_cnt, 1);
        check("t1_eol", eol_cnt, H);
        check("t1_eof", eof_cnt, 1);
        check("t1_done", done_cnt, 1);
        check("t1_flush_samples", flush_cnt, W + 1);
        check("t1_flush_low", int'(flush_req), 0);

        // Ramp n*16: interior pixel equals its sample index.
        clear_counts();
        run_frame(1, 60, -1, 1'b1);
        drain("t2_drain");
        check("t2_flush_samples", flush_cnt, W + 1);
        check("t2_done", done_cnt, 1);

        // Saturating magnitude.
        clear_counts();
        run_frame(2, 80, -1, 1'b0);
        drain("t3_drain");
        check("t3_done", done_cnt, 1);

        // Sink stalled for a whole frame.
        ready_pct = 0; cap = DEPTH; pushed = 0;
        cycle(1'b1, 1'b1, 0);
        for (int s = 1; s < TOTAL; s++) begin
            if (s == W + 1 + DEPTH + 1) check("t4_ovf_before_drop", int'(overflow), 0);
            cycle(1'b0, 1'b1, s * 16);
            if (s == W + 1 + DEPTH + 1) check("t4_ovf_after_drop", int'(overflow), 1);
        end
        cycle(1'b0, 1'b0, 0);
        check("t4_ovf_sticky", int'(overflow), 1);
        check("t4_head_valid", int'(pix_valid), 1);
        clear_counts();
        ready_pct = 100;
        drain("t4_drain");
        cap = -1;
        check("t4_done", done_cnt, 0);
        check("t4_ovf_held", int'(overflow), 1);

        // Frame restart at sample 20 with a coincident sample.
        clear_counts();
        run_frame(1, 80, 20, 1'b1);
        check("t5_ovf_cleared", int'(overflow), 0);
        run_frame(3, 60, -1, 1'b1);
        drain("t5_drain");
        check("t5_done", done_cnt, 1);
        check("t5_eof", eof_cnt, 1);

        // Reset in the middle of the active region.
        run_frame(3, 100, 30, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 0);
        check("t6_pre_reset_q", exp_q.size(), 0);
        rst_n = 1'b0;
        ref_n = -1;
        #1;
        check("t6_reset_outputs", out_word(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 'h3FFFF);
        check("t6_no_pix", int'(pix_valid), 0);
        check("t6_no_flush", int'(flush_req), 0);
        clear_counts();
        run_frame(3, 70, -1, 1'b0);
        drain("t6_drain");
        check("t6_done", done_cnt, 1);

        // Random magnitudes with a randomly stalling sink.
        clear_counts();
        ready_pct = 70;
        run_frame(3, 30, -1, 1'b0);
        ready_pct = 100;
        drain("t7_drain");
        check("t7_done", done_cnt, 1);
        check("t7_overflow", int'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
